umi_tile_router: RTL and testbench
==================================

Name: umi_tile_router

Overview:
- Per-tile UMI router for the RISC-V grid.
- Sits directly upstream of a tile's UMI RX port and directly downstream of its UMI TX port.
- Steers network packets addressed to this tile into the tile. Forwards all other network packets, plus the tile's own outbound packets, onto the next network hop.
- Both outputs are registered; the shared network output uses round-robin arbitration.

Parameters:
- PW, 256, UMI packet width in bits.
- DEST_LSB, 224, bit position of the LSB of the destination tile field within a packet.
- DEST_WIDTH, 8, width of the destination tile field.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- tile_id  input  DEST_WIDTH  this tile's ID; static after reset.
- net_in_packet  input  PW  packet arriving from the previous hop.
- net_in_valid  input  1  net_in packet valid.
- net_in_ready  output  1  net_in packet accepted this cycle.
- tile_tx_packet  input  PW  packet from the tile's UMI TX port.
- tile_tx_valid  input  1  tile_tx packet valid.
- tile_tx_ready  output  1  tile_tx packet accepted this cycle.
- tile_rx_packet  output  PW  packet to the tile's UMI RX port.
- tile_rx_valid  output  1  tile_rx packet valid.
- tile_rx_ready  input  1  tile accepts the packet.
- net_out_packet  output  PW  packet to the next hop.
- net_out_valid  output  1  net_out packet valid.
- net_out_ready  input  1  next hop accepts the packet.

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high.
- Transfer rule: a transfer on any port occurs when valid && ready are both high at a posedge.
- Destination: dest = packet[DEST_LSB+DEST_WIDTH-1:DEST_LSB].
- Routing:
  - net_in with dest == tile_id goes to tile_rx.
  - net_in with dest != tile_id goes to net_out.
  - tile_tx always goes to net_out, including when its dest == tile_id; there is no internal loopback.
- Output stages: tile_rx and net_out are each a one-entry output register (valid + packet).
  - A stage can load when it is empty, or when it is draining this cycle (out_valid && out_ready).
  - Latency is exactly 1 cycle from input transfer to output valid.
  - Throughput is one packet per cycle per output.
- Arbitration for net_out:
  - Requesters: forward_req = net_in_valid && dest != tile_id; tx_req = tile_tx_valid.
  - One-bit pointer rr, reset to 0.
  - With a single requester, that requester is granted.
  - With both requesting: rr=0 grants net_in; rr=1 grants tile_tx.
  - rr updates only on an actual net_out load: it becomes 1 after a net_in load and 0 after a tile_tx load.
- Ready signals (combinational, from current state and inputs):
  - net_in_ready = (dest == tile_id) ? tile_rx_can_load : (net_out_can_load && net_in granted).
  - tile_tx_ready = net_out_can_load && tile_tx granted.
  - tile_tx_ready does not depend on tile_tx_valid.
  - net_in_ready depends on net_in_packet through dest. This is permitted because net_in_packet must be stable while valid.
- Concurrency: a local net_in packet (to tile_rx) and a tile_tx packet (to net_out) are accepted in the same cycle with no interaction.
- Backpressure: while out_valid && !out_ready, the output packet and valid hold stable and are never overwritten.
- Output packet contents equal the accepted input bit-for-bit. No field is modified.
- Reset values: tile_rx_valid=0, net_out_valid=0, rr=0. Packet registers may be left unreset.
  - During rst, net_in_ready=0 and tile_tx_ready=0.
- Reset mid-operation: buffered packets are discarded. Outputs go invalid on the cycle after rst is sampled high.
- No packet is ever dropped or duplicated outside of reset.
- Implementation assertion: neither input's valid may fall without a transfer.

Test Plan:
- Local delivery: tile_id=3; net_in packet with dest=3, data 0xA5…; tile_rx_ready=1.
  -> tile_rx_valid is high one cycle later with an identical packet; net_out_valid stays 0.
- Forwarding: tile_id=3; net_in dest=7 and tile_tx dest=3 held valid continuously; net_out_ready=1.
  -> net_out alternates net_in, tile_tx, net_in, tile_tx…; each source gets 50% throughput.
- Backpressure: net_out_ready=0 with net_out full.
  -> net_out_packet stays stable for 10 cycles; net_in_ready=0 for dest≠tile_id; tile_tx_ready=0.
  -> A dest==tile_id net_in is still accepted in that window.
- Full throughput: 8 back-to-back local packets with tile_rx_ready=1.
  -> 8 consecutive tile_rx transfers, no bubbles, order preserved.
- Concurrent paths: local net_in and tile_tx valid in the same cycle.
  -> Both ready=1; tile_rx and net_out are both valid on the next cycle.
- Reset mid-operation: both outputs full and stalled; assert rst for 1 cycle.
  -> Both valids are 0 next cycle; rr=0; a subsequent contested cycle grants net_in first.

Source files
------------

// File: rtl/umi_tile_router.sv
// Per-tile UMI router: steers network packets addressed to this tile into the tile,
// and forwards everything else (plus the tile's own TX traffic) to the next hop.
module umi_tile_router #(
  parameter int PW         = 256,
  parameter int DEST_LSB   = 224,
  parameter int DEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEST_WIDTH-1:0] tile_id,
  input  logic [PW-1:0]         net_in_packet,
  input  logic                  net_in_valid,
  output logic                  net_in_ready,
  input  logic [PW-1:0]         tile_tx_packet,
  input  logic                  tile_tx_valid,
  output logic                  tile_tx_ready,
  output logic [PW-1:0]         tile_rx_packet,
  output logic                  tile_rx_valid,
  input  logic                  tile_rx_ready,
  output logic [PW-1:0]         net_out_packet,
  output logic                  net_out_valid,
  input  logic                  net_out_ready
);

  logic [DEST_WIDTH-1:0] net_in_dest;
  logic                  net_in_local;
  logic                  rx_can_load;
  logic                  out_can_load;
  logic                  forward_req;
  logic                  net_in_granted;
  logic                  tile_tx_granted;
  logic                  rx_load;
  logic                  out_load_net;
  logic                  out_load_tx;
  logic                  rr;

  assign net_in_dest  = net_in_packet[DEST_LSB +: DEST_WIDTH];
  assign net_in_local = (net_in_dest == tile_id);

  // Grants are derived without looking at the requester's own valid, so tile_tx_ready
  // stays independent of tile_tx_valid; only the competing request can block a grant.
  always_comb begin
    rx_can_load     = !tile_rx_valid || tile_rx_ready;
    out_can_load    = !net_out_valid || net_out_ready;
    forward_req     = net_in_valid && !net_in_local;
    net_in_granted  = !(tile_tx_valid && rr);
    tile_tx_granted = !(forward_req && !rr);
    net_in_ready    = 1'b0;
    tile_tx_ready   = 1'b0;
    if (!rst) begin
      net_in_ready  = net_in_local ? rx_can_load : (out_can_load && net_in_granted);
      tile_tx_ready = out_can_load && tile_tx_granted;
    end
    rx_load      = net_in_valid && net_in_ready && net_in_local;
    out_load_net = net_in_valid && net_in_ready && !net_in_local;
    out_load_tx  = tile_tx_valid && tile_tx_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_rx_valid <= 1'b0;
      net_out_valid <= 1'b0;
      rr            <= 1'b0;
    end else begin
      if (rx_load)
        tile_rx_valid <= 1'b1;
      else if (tile_rx_ready)
        tile_rx_valid <= 1'b0;

      if (out_load_net || out_load_tx)
        net_out_valid <= 1'b1;
      else if (net_out_ready)
        net_out_valid <= 1'b0;

      if (out_load_net)
        rr <= 1'b1;
      else if (out_load_tx)
        rr <= 1'b0;
    end
  end

  // Packet registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rx_load)
      tile_rx_packet <= net_in_packet;
    if (out_load_net)
      net_out_packet <= net_in_packet;
    else if (out_load_tx)
      net_out_packet <= tile_tx_packet;
  end

`ifndef SYNTHESIS
  a_net_in_hold : assert property (@(posedge clk) disable iff (rst)
    (net_in_valid && !net_in_ready) |=> net_in_valid);
  a_tile_tx_hold : assert property (@(posedge clk) disable iff (rst)
    (tile_tx_valid && !tile_tx_ready) |=> tile_tx_valid);
`endif

endmodule

// File: tb/tb_umi_tile_router.sv
// Directed self-checking bench for umi_tile_router with hand-computed expectations.
module tb_umi_tile_router;

  logic         clk;
  logic         rst;
  logic [7:0]   tile_id;
  logic [255:0] net_in_packet;
  logic         net_in_valid;
  logic         net_in_ready;
  logic [255:0] tile_tx_packet;
  logic         tile_tx_valid;
  logic         tile_tx_ready;
  logic [255:0] tile_rx_packet;
  logic         tile_rx_valid;
  logic         tile_rx_ready;
  logic [255:0] net_out_packet;
  logic         net_out_valid;
  logic         net_out_ready;

  int testsRun;
  int testsFailed;

  umi_tile_router #(.PW(256), .DEST_LSB(224), .DEST_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .tile_id        (tile_id),
    .net_in_packet  (net_in_packet),
    .net_in_valid   (net_in_valid),
    .net_in_ready   (net_in_ready),
    .tile_tx_packet (tile_tx_packet),
    .tile_tx_valid  (tile_tx_valid),
    .tile_tx_ready  (tile_tx_ready),
    .tile_rx_packet (tile_rx_packet),
    .tile_rx_valid  (tile_rx_valid),
    .tile_rx_ready  (tile_rx_ready),
    .net_out_packet (net_out_packet),
    .net_out_valid  (net_out_valid),
    .net_out_ready  (net_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [7:0] dest, input logic [7:0] fill);
    logic [255:0] p;
    p = {32{fill}};
    p[231:224] = dest;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the active edge; checks happen on the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  logic [255:0] pktF, pktT, prev;
  logic         expNet;

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    rst            = 1'b1;
    tile_id        = 8'd3;
    net_in_packet  = mk(8'd3, 8'hA5);
    net_in_valid   = 1'b0;
    tile_tx_packet = mk(8'd7, 8'h00);
    tile_tx_valid  = 1'b0;
    tile_rx_ready  = 1'b1;
    net_out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    settle;
    checkOutput("rst_net_in_ready", net_in_ready, 0);
    checkOutput("rst_tile_tx_ready", tile_tx_ready, 0);
    checkOutput("rst_rx_valid", tile_rx_valid, 0);
    checkOutput("rst_out_valid", net_out_valid, 0);
    tick;
    rst = 1'b0;

    // Local delivery
    net_in_packet = mk(8'd3, 8'hA5);
    net_in_valid  = 1'b1;
    settle;
    checkOutput("local_ready", net_in_ready, 1);
    tick;
    net_in_valid = 1'b0;
    settle;
    checkOutput("local_rx_valid", tile_rx_valid, 1);
    checkOutput("local_rx_packet", tile_rx_packet, mk(8'd3, 8'hA5));
    checkOutput("local_out_valid", net_out_valid, 0);

    // Concurrent paths; tile_tx addressed to this tile must still go out to the network
    tick;
    net_in_packet  = mk(8'd3, 8'hB1);
    net_in_valid   = 1'b1;
    tile_tx_packet = mk(8'd3, 8'hC3);
    tile_tx_valid  = 1'b1;
    settle;
    checkOutput("conc_net_in_ready", net_in_ready, 1);
    checkOutput("conc_tile_tx_ready", tile_tx_ready, 1);
    tick;
    net_in_valid  = 1'b0;
    tile_tx_valid = 1'b0;
    settle;
    checkOutput("conc_rx_valid", tile_rx_valid, 1);
    checkOutput("conc_rx_packet", tile_rx_packet, mk(8'd3, 8'hB1));
    checkOutput("conc_out_valid", net_out_valid, 1);
    checkOutput("conc_out_packet", net_out_packet, mk(8'd3, 8'hC3));
    tick;
    settle;
    checkOutput("conc_drain_rx", tile_rx_valid, 0);
    checkOutput("conc_drain_out", net_out_valid, 0);

    // Forwarding alternation; rr is 0 after the tile_tx load above
    pktF = mk(8'd7, 8'h0F);
    pktT = mk(8'd3, 8'h77);
    tick;
    net_in_packet  = pktF;
    net_in_valid   = 1'b1;
    tile_tx_packet = pktT;
    tile_tx_valid  = 1'b1;
    prev           = '0;
    for (int i = 0; i < 6; i++) begin
      expNet = (i % 2 == 0);
      settle;
      checkOutput($sformatf("fwd_net_in_ready_%0d", i), net_in_ready, expNet);
      checkOutput($sformatf("fwd_tile_tx_ready_%0d", i), tile_tx_ready, !expNet);
      if (i > 0) checkOutput($sformatf("fwd_out_packet_%0d", i), net_out_packet, prev);
      prev = expNet ? pktF : pktT;
      tick;
    end
    tile_tx_valid = 1'b0;
    settle;
    checkOutput("fwd_out_last_tx", net_out_packet, pktT);
    checkOutput("fwd_net_in_alone", net_in_ready, 1);
    tick;
    net_in_valid  = 1'b0;
    net_out_ready = 1'b0;
    settle;
    checkOutput("fwd_out_last_net", net_out_packet, pktF);

    // Backpressure: net_out stalled holding pktF; local traffic still flows
    tile_tx_packet = mk(8'd3, 8'hE2);
    tile_tx_valid  = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) begin
        net_in_packet = mk(8'd3, 8'h40 + 8'(i));
        net_in_valid  = 1'b1;
      end else begin
        net_in_packet = mk(8'd7, 8'h66);
        net_in_valid  = 1'b0;
      end
      settle;
      checkOutput($sformatf("bp_out_valid_%0d", i), net_out_valid, 1);
      checkOutput($sformatf("bp_out_packet_%0d", i), net_out_packet, pktF);
      checkOutput($sformatf("bp_tile_tx_ready_%0d", i), tile_tx_ready, 0);
      checkOutput($sformatf("bp_net_in_ready_%0d", i), net_in_ready, (i % 2 == 1));
      tick;
    end
    net_in_valid  = 1'b0;
    net_out_ready = 1'b1;
    settle;
    checkOutput("bp_rx_packet", tile_rx_packet, mk(8'd3, 8'h49));
    checkOutput("bp_rx_valid", tile_rx_valid, 1);
    checkOutput("bp_release_tx_ready", tile_tx_ready, 1);
    tick;
    tile_tx_valid = 1'b0;
    settle;
    checkOutput("bp_out_after_release", net_out_packet, mk(8'd3, 8'hE2));

    // Full throughput: 8 back-to-back local packets
    tick;
    for (int i = 0; i < 8; i++) begin
      net_in_packet = mk(8'd3, 8'h80 + 8'(i));
      net_in_valid  = 1'b1;
      settle;
      checkOutput($sformatf("thr_ready_%0d", i), net_in_ready, 1);
      if (i > 0) begin
        checkOutput($sformatf("thr_rx_valid_%0d", i), tile_rx_valid, 1);
        checkOutput($sformatf("thr_rx_packet_%0d", i), tile_rx_packet, mk(8'd3, 8'h80 + 8'(i - 1)));
      end
      tick;
    end
    net_in_valid = 1'b0;
    settle;
    checkOutput("thr_rx_last", tile_rx_packet, mk(8'd3, 8'h87));
    checkOutput("thr_out_idle", net_out_valid, 0);

    // Reset mid-operation: set rr=1 via a forward, fill both outputs, then reset
    tick;
    net_in_packet = mk(8'd7, 8'h58);
    net_in_valid  = 1'b1;
    net_out_ready = 1'b0;
    settle;
    checkOutput("mid_fwd_ready", net_in_ready, 1);
    tick;
    net_in_packet = mk(8'd3, 8'h59);
    tile_rx_ready = 1'b0;
    settle;
    checkOutput("mid_local_ready", net_in_ready, 1);
    tick;
    net_in_valid = 1'b0;
    settle;
    checkOutput("mid_full_rx", tile_rx_valid, 1);
    checkOutput("mid_full_out", net_out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_tile_tx_ready", tile_tx_ready, 0);
    tick;
    rst            = 1'b0;
    tile_rx_ready  = 1'b1;
    net_out_ready  = 1'b1;
    net_in_packet  = mk(8'd7, 8'h58);
    net_in_valid   = 1'b1;
    tile_tx_packet = mk(8'd3, 8'h5A);
    tile_tx_valid  = 1'b1;
    settle;
    checkOutput("mid_rx_cleared", tile_rx_valid, 0);
    checkOutput("mid_out_cleared", net_out_valid, 0);
    checkOutput("mid_contest_net_in", net_in_ready, 1);
    checkOutput("mid_contest_tile_tx", tile_tx_ready, 0);
    tick;
    net_in_valid = 1'b0;
    settle;
    checkOutput("mid_out_first", net_out_packet, mk(8'd7, 8'h58));
    checkOutput("mid_tx_next_ready", tile_tx_ready, 1);
    tick;
    tile_tx_valid = 1'b0;
    settle;
    checkOutput("mid_out_second", net_out_packet, mk(8'd3, 8'h5A));
    checkOutput("mid_rx_untouched", tile_rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
